bsearch_ctrl: RTL and testbench
===============================

// Module: bsearch_ctrl
// PURPOSE
//  Binary-search sequencer that drives the 8-bit comparator: registers the
//  search target onto data_t, addresses a sorted (ascending) sync-read RAM
//  whose output feeds ramout, and steers low/high bounds from gt/eq/lt.
//  Sits between the host start/result interface and the comparator/RAM pair.
// PARAMETERS
//  DATA_W  8   width of target and RAM words (matches comparator)
//  ADDR_W  5   RAM address width; DEPTH = 2**ADDR_W entries, all searched
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       begin search; sampled only in IDLE
//  data_in     in   DATA_W  search target, captured when start accepted
//  data_t      out  DATA_W  registered target to comparator
//  addr        out  ADDR_W  RAM read address (registered)
//  gt/eq/lt    in   1 each  comparator flags for data_t vs ramout
//  busy        out  1       high from accepted start until DONE exit
//  done        out  1       one-cycle pulse at search completion
//  found       out  1       target present; valid from done, held to next start
//  found_addr  out  ADDR_W  address of match; held to next start
//  err         out  1       flags not one-hot at a compare; held to next start
// BEHAVIOUR
//  Reset: state=IDLE; data_t, addr, found_addr = 0; busy, done, found, err = 0.
//  Bounds low/high are ADDR_W+1 bits (no wrap); mid = (low+high)>>1.
//  States:
//   IDLE : start=1 -> data_t<=data_in, low<=0, high<=DEPTH-1, clear found,
//          found_addr, err; busy<=1 -> CALC. start=0 -> stay.
//   CALC : addr<=mid[ADDR_W-1:0] -> WAIT.
//   WAIT : one cycle for RAM read latency -> CMP.
//   CMP  : flags sampled here only.
//          not exactly one of gt/eq/lt -> err<=1, found<=0 -> DONE.
//          eq -> found<=1, found_addr<=addr -> DONE.
//          gt -> low<=mid+1; lt -> high<=mid-1. If mid==0 on lt (underflow)
//          or new low>high -> found<=0 -> DONE; else -> CALC.
//   DONE : done=1 for this cycle, busy<=0 -> IDLE.
//  Latency: 3 cycles per compare; worst case ADDR_W+1 compares;
//   start-to-done <= 1 + 3*(ADDR_W+1) cycles (19 for default).
//  start while busy: ignored, no effect on an in-flight search.
//  start in the DONE cycle: ignored; first accept is next IDLE cycle.
//  Target change on data_in mid-search: no effect (data_t is latched).
//  rst_n low mid-search: immediate return to IDLE with reset values; no done.
// STRUCTURE
//  Shared package bsearch_pkg: state enum (IDLE, CALC, WAIT, CMP, DONE),
//   DATA_W/ADDR_W defaults, flag-legality function (one-hot check).
//  Single module; comparator and RAM stay external and are instantiated
//   beside this block at the next level up. No sub-module needed.
// TESTING
//  Bench RAM model: sync read, mem[i] = 2*i+1 (1..63), real comparator.
//  1 start, data_in=8'h21 -> found=1, found_addr=16, addr sequence
//    15,23,19,17,16, done at cycle 16 after start.
//  2 data_in=8'h00 -> found=0 via lt with mid=0 (no underflow); busy
//    clears; err=0.
//  3 data_in=8'h3F -> found_addr=31; data_in=8'h40 -> found=0 with low=32,
//    no address wrap.
//  4 start pulses during busy with data_in=8'h05 -> ignored; original
//    search result unchanged.
//  5 Assert rst_n=0 at cycle 5 of a search -> all outputs at reset values;
//    no done pulse. Next start completes normally.
//  6 Force gt=eq=1 in CMP -> err=1, found=0, done pulse.
//  Also: 500 random targets vs a reference model, checking found/found_addr
//  and the latency bound.

Source files
------------

// File: rtl/bsearch_pkg.sv
// Shared types and helpers for the binary-search sequencer.
package bsearch_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    WAIT = 3'd2,
    CMP  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Comparator flags are legal only when exactly one is set.
  function automatic logic flags_ok(input logic gt, input logic eq, input logic lt);
    case ({gt, eq, lt})
      3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
      default:                flags_ok = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/bsearch_ctrl.sv
// Binary-search sequencer: walks a sorted sync-read RAM through an external
// comparator, narrowing low/high bounds until a match or an empty range.
module bsearch_ctrl
  import bsearch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_t,
  output logic [ADDR_W-1:0] addr,
  input  logic              gt,
  input  logic              eq,
  input  logic              lt,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] found_addr,
  output logic              err
);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] HIGH_INIT = (ADDR_W+1)'((2**ADDR_W) - 1);

  state_t          state, state_nx;
  logic [ADDR_W:0] low, high;
  logic [ADDR_W:0] mid, mid_inc, mid_dec;
  logic            legal, range_empty;

  // Bounds carry one extra bit so low can pass DEPTH-1 without wrapping.
  assign mid     = (low + high) >> 1;
  assign mid_inc = mid + ONE;
  assign mid_dec = mid - ONE;
  assign legal   = flags_ok(gt, eq, lt);

  // mid==0 on lt would wrap high, so it terminates the search directly.
  assign range_empty = lt ? ((mid == '0) || (low > mid_dec)) : (mid_inc > high);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = CALC;
      CALC: state_nx = WAIT;
      WAIT: state_nx = CMP;
      CMP:  state_nx = (!legal || eq || range_empty) ? DONE : CALC;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_t     <= '0;
      addr       <= '0;
      low        <= '0;
      high       <= '0;
      busy       <= 1'b0;
      found      <= 1'b0;
      found_addr <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          data_t     <= data_in;
          low        <= '0;
          high       <= HIGH_INIT;
          found      <= 1'b0;
          found_addr <= '0;
          err        <= 1'b0;
          busy       <= 1'b1;
        end
        CALC: addr <= mid[ADDR_W-1:0];
        CMP: begin
          if (!legal) begin
            err   <= 1'b1;
            found <= 1'b0;
          end else if (eq) begin
            found      <= 1'b1;
            found_addr <= addr;
          end else begin
            if (gt) low  <= mid_inc;
            else    high <= mid_dec;
            if (range_empty) found <= 1'b0;
          end
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bsearch_ctrl.sv
// Scoreboard bench for bsearch_ctrl: sync-read RAM of odd numbers, real
// comparator, directed corner cases plus random targets vs a reference model.
module tb_bsearch_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2**ADDR_W;
  localparam int MAX_LAT = 1 + 3*(ADDR_W+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_t;
  logic [ADDR_W-1:0] addr;
  logic              gt, eq, lt;
  logic              busy, done, found, err;
  logic [ADDR_W-1:0] found_addr;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ramout;
  logic              force_bad = 1'b0;

  bsearch_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .data_t(data_t), .addr(addr), .gt(gt), .eq(eq), .lt(lt),
    .busy(busy), .done(done), .found(found), .found_addr(found_addr), .err(err)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(2*i + 1);
  always @(posedge clk) ramout <= mem[addr];

  assign gt = force_bad ? 1'b1 : (data_t > ramout);
  assign eq = force_bad ? 1'b1 : (data_t == ramout);
  assign lt = force_bad ? 1'b0 : (data_t < ramout);

  typedef struct {
    int t; int found; int faddr; int err; int lat; int start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   addr_log[$];
  bit   log_en = 1'b0;
  int   last_addr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Compare count from a plain integer binary search over mem[i]=2i+1.
  function automatic int ref_compares(input int t);
    int lo = 0, hi = DEPTH-1, m, v, n = 0;
    while (1) begin
      m = (lo + hi) / 2;
      v = 2*m + 1;
      n++;
      if (v == t) break;
      if (t > v) lo = m + 1;
      else begin
        if (m == 0) break;
        hi = m - 1;
      end
      if (lo > hi) break;
    end
    return n;
  endfunction

  function automatic exp_t make_exp(input int t, input bit bad, input int sc);
    exp_t e;
    e.t = t; e.start_cyc = sc;
    if (bad) begin
      e.found = 0; e.faddr = 0; e.err = 1; e.lat = 4;
    end else begin
      e.err   = 0;
      e.found = (t % 2 == 1 && t <= 2*DEPTH - 1) ? 1 : 0;
      e.faddr = e.found ? (t - 1) / 2 : 0;
      e.lat   = 1 + 3*ref_compares(t);
    end
    return e;
  endfunction

  // Monitor: pops an expectation on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    int lat;
    if (!rst_n) begin
      exp_q.delete();
      if (done) chk("done_in_reset", 1, 0);
    end else begin
      if (log_en && busy && int'(addr) != last_addr) begin
        addr_log.push_back(int'(addr));
        last_addr = int'(addr);
      end
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          lat = cyc - e.start_cyc;
          chk($sformatf("found[t=%0d]", e.t), int'(found), e.found);
          if (e.found != 0) chk($sformatf("found_addr[t=%0d]", e.t), int'(found_addr), e.faddr);
          chk($sformatf("err[t=%0d]", e.t), int'(err), e.err);
          chk($sformatf("latency[t=%0d]", e.t), lat, e.lat);
          if (lat > MAX_LAT) chk("latency_bound", lat, MAX_LAT);
        end
      end
    end
  end

  task automatic issue(input int t, input bit bad);
    @(negedge clk);
    data_in = DATA_W'(t);
    start   = 1'b1;
    if (!busy && rst_n) exp_q.push_back(make_exp(t, bad, cyc));
    @(negedge clk);
    start   = 1'b0;
    data_in = DATA_W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", int'(busy), 0);
    @(negedge clk);
  endtask

  task automatic search(input int t);
    issue(t, 1'b0);
    wait_idle();
  endtask

  initial begin
    int want[5] = '{15, 23, 19, 17, 16};
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({data_t, addr, found_addr, busy, done, found, err}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: match at index 16 with the expected address walk.
    log_en = 1'b1;
    search(8'h21);
    log_en = 1'b0;
    chk("addr_seq_len", addr_log.size(), 5);
    for (int i = 0; i < 5 && i < addr_log.size(); i++)
      chk($sformatf("addr_seq[%0d]", i), addr_log[i], want[i]);
    chk("found_held", int'(found), 1);

    search(8'h00);
    chk("busy_cleared", int'(busy), 0);
    search(8'h3F);
    search(8'h40);
    chk("no_wrap_addr", int'(addr), 31);

    // Start pulses while busy must not disturb the running search.
    issue(8'h21, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_in = 8'h05;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
    end
    wait_idle();
    chk("busy_ignore_result", int'(found_addr), 16);

    // Reset mid-search.
    issue(8'h2B, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", int'({data_t, addr, found_addr, busy, done, found, err}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    search(8'h2B);

    // Illegal flags at compare.
    force_bad = 1'b1;
    issue(8'h11, 1'b1);
    wait_idle();
    force_bad = 1'b0;
    chk("err_held", int'(err), 1);
    search(8'h11);
    chk("err_cleared", int'(err), 0);

    for (int i = 0; i < 500; i++) search(int'($urandom_range(0, 70)));

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
